// File: rtl/sockit_ghrd_debounce_pio_if.sv
// Memory-mapped slave bus for the debounced PIO: word-addressed register
// access with registered read data, plus the level interrupt.
interface sockit_ghrd_debounce_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/sockit_ghrd_debounce_pio.sv
// Debounced input PIO: synchronises external inputs, qualifies each channel
// for DB_CYCLES consecutive samples, and latches enabled edges for interrupts.
module sockit_ghrd_debounce_pio #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_port,
    sockit_ghrd_debounce_pio_if.slave bus
);

    localparam int CNT_W = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (DB_CYCLES > 0) ? CNT_W'(DB_CYCLES - 1) : '0;

    logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_nxt;
    logic [31:0]      readdata_q;
    logic             unused_wdata;

    assign sync         = sync_chain[SYNC_STAGES-1];
    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    // Per-channel qualification: the counter only runs while the synchronised
    // input disagrees with the debounced value and saturates at the update.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            stable_nxt[i] = stable[i];
            cnt_nxt[i]    = '0;
            if (DB_CYCLES == 0) begin
                stable_nxt[i] = sync[i];
            end else if (sync[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = sync[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise    = ~stable & stable_nxt;
    assign fall    = stable & ~stable_nxt;
    assign cap_set = (rise & rise_en) | (fall & fall_en);
    assign cap_clr = (wr_en && bus.address == 3'd3) ? wdata : '0;

    always_comb begin
        rd_nxt = '0;
        case (bus.address)
            3'd0:    rd_nxt[WIDTH-1:0] = stable;
            3'd1:    rd_nxt[WIDTH-1:0] = sync;
            3'd2:    rd_nxt[WIDTH-1:0] = irq_mask;
            3'd3:    rd_nxt[WIDTH-1:0] = edge_capture;
            3'd4:    rd_nxt[WIDTH-1:0] = rise_en;
            3'd5:    rd_nxt[WIDTH-1:0] = fall_en;
            default: rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_chain[k] <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
            stable       <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            rise_en      <= '1;
            fall_en      <= '1;
            readdata_q   <= '0;
        end else begin
            sync_chain[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) sync_chain[k] <= sync_chain[k-1];
            for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
            stable       <= stable_nxt;
            // Software clear beats a capture landing on the same edge.
            edge_capture <= (edge_capture | cap_set) & ~cap_clr;
            if (wr_en && bus.address == 3'd2) irq_mask <= wdata;
            if (wr_en && bus.address == 3'd4) rise_en  <= wdata;
            if (wr_en && bus.address == 3'd5) fall_en  <= wdata;
            readdata_q   <= rd_nxt;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edge_capture & irq_mask);

endmodule

// File: doc/sockit_ghrd_debounce_pio.md
SOCKIT_GHRD_DEBOUNCE_PIO -- requirements
Module: sockit_ghrd_debounce_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of input channels, legal 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal 2..4.
REQ-003 SHALL have parameter DB_CYCLES, default 50000: debounce qualification count; 0 = debounce bypassed.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port address, input, 3: register word select.
REQ-007 SHALL have port chipselect, input, 1: slave select.
REQ-008 SHALL have port write_n, input, 1: active-low write strobe.
REQ-009 SHALL have port writedata, input, 32: write data.
REQ-010 SHALL have port in_port, input, WIDTH: asynchronous external inputs.
REQ-011 SHALL have port readdata, output, 32: registered read data.
REQ-012 SHALL have port irq, output, 1: level interrupt, active-high.

Function
REQ-013 SHALL pass each in_port bit through a SYNC_STAGES-deep flop chain; the last stage is "sync".
REQ-014 SHALL keep a per-channel "stable" bit and a debounce counter of width clog2(DB_CYCLES+1).
REQ-015 SHALL, while sync != stable, increment that channel's counter each cycle; it SHALL clear the counter on any cycle where sync == stable.
REQ-016 SHALL, when sync != stable and counter == DB_CYCLES-1, load stable <= sync and clear the counter: the update happens on the DB_CYCLES-th consecutive mismatching sample.
REQ-017 SHALL, when DB_CYCLES == 0, load stable <= sync every cycle.
REQ-018 SHALL treat a stable 0->1 update as a rise event and a 1->0 update as a fall event.
REQ-019 SHALL set edge_capture[i] on the same clock edge as the stable update when (rise & rise_en[i]) | (fall & fall_en[i]).
REQ-020 SHALL keep edge_capture[i] set until it is cleared by software.
REQ-021 SHALL decode the register map as follows:
- 0: stable data, RO.
- 1: sync raw data, RO.
- 2: irq_mask, RW.
- 3: edge_capture, write-1-to-clear.
- 4: rise_en, RW.
- 5: fall_en, RW.
- 6 and 7: read 0, writes ignored.
REQ-022 SHALL perform a write when chipselect=1 and write_n=0; only bits [WIDTH-1:0] are used.
REQ-023 SHALL, on a simultaneous W1C and set event on the same bit, let the clear win (the bit reads 0).
REQ-024 SHALL register readdata every cycle from the address mux, independent of chipselect: 1-cycle read latency, bits [31:WIDTH] = 0.
REQ-025 SHALL drive irq combinationally as |(edge_capture & irq_mask).
REQ-026 SHALL give a total latency from in_port change to stable change of SYNC_STAGES + DB_CYCLES cycles (+0/1 for async sampling).
REQ-027 SHALL restart qualification from 0 when a glitch shorter than DB_CYCLES cycles occurs; no stable change and no capture result.
REQ-028 SHALL let mask or enable writes take effect on the next cycle and SHALL NOT alter existing edge_capture bits.
REQ-029 SHALL, at counter width rule, never let the counter exceed DB_CYCLES-1 (no wrap).

Reset
REQ-030 SHALL, on reset asserted, asynchronously clear the sync chains, stable, counters, edge_capture, irq_mask and readdata to 0, giving irq = 0.
REQ-031 SHALL reset rise_en and fall_en to all ones (any-edge capture).
REQ-032 SHALL, on reset mid-qualification, discard the pending transition; after release, an in_port held at 1 requalifies from counter 0.

Verification (WIDTH=4, SYNC_STAGES=2, DB_CYCLES=4)
REQ-033 SHALL cover: in_port 0->0x1 held → stable bit0 = 1 exactly 6 cycles later; read addr 0 → 0x1; addr 3 → 0x1.
REQ-034 SHALL cover: 3-cycle pulse on in_port[2] → addr 0 stays 0x0, addr 3 stays 0x0, addr 1 shows the pulse.
REQ-035 SHALL cover: rise_en=0x0, fall_en=0xF, in_port[1] 1->0 after qualified 1 → only the fall sets edge_capture bit1 = 1.
REQ-036 SHALL cover: irq_mask=0x2 with edge_capture=0x3 → irq = 1; write 0x2 to addr 3 → edge_capture = 0x1, irq = 0.
REQ-037 SHALL cover: W1C of bit0 on the exact stable-update cycle → edge_capture[0] = 0, and a stable change still occurs.
REQ-038 SHALL cover: reset pulse at counter = 2 → all registers read 0, rise_en/fall_en read 0xF, and requalification takes a full 6 cycles.
